// File: rtl/jtkicker_romslot_pkg.sv
// Shared types and default widths for the ROM fetch slot that bridges
// 32-bit tile-engine reads onto two-beat 16-bit SDRAM bursts.
package jtkicker_romslot_pkg;

  localparam int AW_DEF       = 13;
  localparam int SDRAM_AW_DEF = 22;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BEAT0 = 2'd2,
    ST_BEAT1 = 2'd3
  } state_t;

endpackage

// File: rtl/jtkicker_romslot_if.sv
// Bundles the consumer-side ROM port and the SDRAM burst port of one slot.
// The slot is the slave; the video consumer plus SDRAM controller form the master.
interface jtkicker_romslot_if
  import jtkicker_romslot_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int SDRAM_AW = SDRAM_AW_DEF
);

  logic                rom_cs;
  logic [AW-1:0]       rom_addr;
  logic [31:0]         rom_data;
  logic                rom_ok;
  logic                sdram_req;
  logic [SDRAM_AW-1:0] sdram_addr;
  logic                sdram_ack;
  logic                sdram_dst;
  logic [15:0]         sdram_data;

  modport master (
    output rom_cs, rom_addr, sdram_ack, sdram_dst, sdram_data,
    input  rom_data, rom_ok, sdram_req, sdram_addr
  );

  modport slave (
    input  rom_cs, rom_addr, sdram_ack, sdram_dst, sdram_data,
    output rom_data, rom_ok, sdram_req, sdram_addr
  );

endinterface

// File: rtl/jtkicker_romslot.sv
// One-entry tagged ROM buffer: a miss issues a two-beat SDRAM burst and the
// assembled 32-bit word is served until the requested address moves away.
module jtkicker_romslot
  import jtkicker_romslot_pkg::*;
#(
  parameter int                  AW       = AW_DEF,
  parameter int                  SDRAM_AW = SDRAM_AW_DEF,
  parameter logic [SDRAM_AW-1:0] OFFSET   = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  jtkicker_romslot_if.slave  io_bus
);

  state_t              r_state;
  logic [AW-1:0]       r_pend;
  logic [AW-1:0]       r_tag;
  logic                r_valid;
  logic [15:0]         r_buf;
  logic [31:0]         r_data;
  logic                r_req;
  logic [SDRAM_AW-1:0] r_addr;

  logic [AW-1:0]       w_addr;
  logic                w_hit;
  logic [SDRAM_AW-1:0] w_map;

  assign w_addr = io_bus.rom_addr;
  assign w_hit  = r_valid && (r_tag == w_addr);
  // Each 32-bit word spans two SDRAM words; the sum wraps silently at the top.
  assign w_map  = OFFSET + SDRAM_AW'({w_addr, 1'b0});

  assign io_bus.rom_ok     = w_hit && io_bus.rom_cs;
  assign io_bus.rom_data   = r_data;
  assign io_bus.sdram_req  = r_req;
  assign io_bus.sdram_addr = r_addr;

  // NOTE: state registers use non-blocking assignments so every branch reads
  // the pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_tag   <= '0;
      r_valid <= 1'b0;
      r_buf   <= '0;
      r_data  <= '0;
      r_req   <= 1'b0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_bus.rom_cs && !w_hit) begin
            r_pend  <= w_addr;
            r_addr  <= w_map;
            r_req   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (io_bus.sdram_ack) begin
            r_req <= 1'b0;
            // The controller may deliver beat 0 in the very cycle it acknowledges.
            if (io_bus.sdram_dst) begin
              r_buf   <= io_bus.sdram_data;
              r_state <= ST_BEAT1;
            end else begin
              r_state <= ST_BEAT0;
            end
          end
        end
        ST_BEAT0: begin
          if (io_bus.sdram_dst) begin
            r_buf   <= io_bus.sdram_data;
            r_state <= ST_BEAT1;
          end
        end
        ST_BEAT1: begin
          if (io_bus.sdram_dst) begin
            r_data  <= {io_bus.sdram_data, r_buf};
            r_tag   <= r_pend;
            r_valid <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
